// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump reader: FSM state encoding
// and register-file geometry constants.
package regfile_dump_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
    CHK  = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam int         NUM_REGS       = 32;
  localparam logic [4:0] CHECKSUM_INDEX = 5'h1F;

endpackage

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks START_INDEX..END_INDEX through the
// register file's combinational read port and streams each value out over a
// valid/ready interface. The CPU is held for as long as a dump is active.
// Optional feature macro: REGFILE_DUMP_CHECKSUM_EN appends one extra word
// carrying the XOR of all dumped words, tagged with an all-ones index.
module regfile_dump_reader
  import regfile_dump_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int START_INDEX = 0,
  parameter int END_INDEX   = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  hold_cpu,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(START_INDEX);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(END_INDEX);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  xfer;
  logic                  at_last;
  logic                  kill;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] chk_acc;
`endif

  assign xfer     = out_valid && out_ready;
  // The counter never steps past END_INDEX, so it cannot wrap even when
  // END_INDEX is the top of the ADDR_WIDTH range.
  assign at_last  = (idx == LAST_IDX);
  assign kill     = abort && (state != IDLE);
  assign rd_addr  = idx;
  assign busy     = (state != IDLE);
  assign hold_cpu = busy;
  assign done     = (state == FIN);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; abort overrides everything, including a transfer.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = READ;
      READ: state_next = SEND;
      SEND: begin
        if (xfer) begin
          if (at_last) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            state_next = CHK;
`else
            state_next = FIN;
`endif
          end else begin
            state_next = READ;
          end
        end
      end
      CHK:     if (xfer) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill) state_next = IDLE;
  end

  // Index counter, output word register and (optionally) the running XOR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= FIRST_IDX;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (kill) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx <= FIRST_IDX;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            chk_acc <= '0;
`endif
          end
        end
        READ: begin
          out_data  <= rd_data;
          out_index <= idx;
          out_valid <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
`else
          out_last  <= at_last;
`endif
        end
        SEND: begin
          if (xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (!at_last) idx <= idx + ADDR_WIDTH'(1);
`ifdef REGFILE_DUMP_CHECKSUM_EN
            chk_acc <= chk_acc ^ out_data;
            // The checksum word follows the final register directly.
            if (at_last) begin
              out_data  <= chk_acc ^ out_data;
              out_index <= '1;
              out_last  <= 1'b1;
              out_valid <= 1'b1;
            end
`endif
          end
        end
        CHK: begin
          if (xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: expected words are queued when a
// dump is started, and a negedge monitor pops and compares on each transfer.
module tb_regfile_dump_reader;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int CHK_EN = 1;
`else
  localparam int CHK_EN = 0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  index;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, out_ready;
  logic [4:0]  rd_addr, out_index;
  logic [31:0] rd_data, out_data;
  logic        out_valid, out_last, busy, hold_cpu, done;

  logic        start_b, abort_b, out_ready_b;
  logic [4:0]  rd_addr_b, out_index_b;
  logic [31:0] rd_data_b, out_data_b;
  logic        out_valid_b, out_last_b, busy_b, hold_cpu_b, done_b;

  logic [31:0] regs   [32];
  logic [31:0] regs_b [32];

  word_t exp_q[$];
  word_t exp_b[$];
  word_t held;
  logic  stall_pend = 1'b0;

  int checks = 0, failures = 0;
  int cyc = 0;
  int n_xfer = 0, done_cnt = 0, done_cyc = 0, last_xfer_cyc = 0;
  int first_valid_cyc = -1, hold_err = 0;
  int nb_xfer = 0, nb_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rd_data   = regs[rd_addr];
  assign rd_data_b = regs_b[rd_addr_b];

  regfile_dump_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .busy(busy), .hold_cpu(hold_cpu), .done(done)
  );

  regfile_dump_reader #(.START_INDEX(3), .END_INDEX(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .out_index(out_index_b),
    .out_last(out_last_b), .busy(busy_b), .hold_cpu(hold_cpu_b), .done(done_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_range(input int lo, input int hi, input bit last_on_hi);
    for (int k = lo; k <= hi; k++)
      exp_q.push_back('{regs[k], 5'(k), (k == hi) && last_on_hi});
  endtask

  // Full 0..31 dump expectation, including the checksum word when enabled.
  task automatic push_full();
    logic [31:0] x;
    x = '0;
    push_range(0, 31, CHK_EN == 0);
    for (int k = 0; k < 32; k++) x ^= regs[k];
    if (CHK_EN != 0) exp_q.push_back('{x, 5'h1F, 1'b1});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, done_cnt != d0, 1);
  endtask

  task automatic wait_index(input logic [4:0] target, input string name);
    int n;
    n = 0;
    while (!(out_valid && out_index == target) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, out_valid && out_index == target, 1);
  endtask

  // Monitor for the main instance: transfers, stall stability, done pulses.
  always @(negedge clk) begin
    word_t e;
    if (rst_n) begin
      if (hold_cpu !== busy) hold_err++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (stall_pend) begin
          check("stall_data", out_data, held.data);
          check("stall_index", out_index, held.index);
        end
        if (out_ready && !abort) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word_idx", out_index, 5'h00);
            check("unexpected_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("word_data", out_data, e.data);
            check("word_index", out_index, e.index);
            check("word_last", out_last, e.last);
          end
          n_xfer++;
          last_xfer_cyc = cyc;
          stall_pend = 1'b0;
        end else begin
          stall_pend = 1'b1;
          held = '{out_data, out_index, out_last};
        end
      end else begin
        stall_pend = 1'b0;
      end
    end else begin
      stall_pend = 1'b0;
    end
  end

  // Monitor for the single-register instance.
  always @(negedge clk) begin
    word_t e;
    if (rst_n) begin
      if (done_b) nb_done++;
      if (out_valid_b && out_ready_b) begin
        nb_xfer++;
        if (exp_b.size() == 0) check("b_unexpected_word", 1, 0);
        else begin
          e = exp_b.pop_front();
          check("b_data", out_data_b, e.data);
          check("b_index", out_index_b, e.index);
          check("b_last", out_last_b, e.last);
        end
      end
    end
  end

  initial begin
    int d0, start_cyc, low_cnt, n;
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    start_b = 1'b0; abort_b = 1'b0; out_ready_b = 1'b1;
    for (int k = 0; k < 32; k++) begin
      regs[k]   = 32'(k) * 32'h11111111;
      regs_b[k] = 32'h0;
    end
    regs_b[3] = 32'hDEADBEEF;

    // Reset state
    #2 rst_n = 1'b0;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_b_rd_addr", rd_addr_b, 3);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    // Test 1: full dump, ready held high
    d0 = done_cnt; n_xfer = 0; hold_err = 0; first_valid_cyc = -1;
    push_full();
    start_cyc = cyc;
    pulse_start();
    wait_done(d0, "t1_done_timeout");
    repeat (2) @(posedge clk); #1;
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_words", n_xfer, 32 + CHK_EN);
    check("t1_latency", first_valid_cyc - start_cyc, 2);
    check("t1_done_after_last", done_cyc - last_xfer_cyc, 1);
    check("t1_total_cycles", done_cyc - start_cyc, 65 + CHK_EN);
    check("t1_single_done", done_cnt, d0 + 1);
    check("t1_hold_eq_busy", hold_err, 0);
    check("t1_busy_after", busy, 0);

    // Test 2: consumer accepts one cycle in three
    d0 = done_cnt; n_xfer = 0; low_cnt = 0;
    out_ready = 1'b0;
    push_full();
    pulse_start();
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (done_cnt != d0) break;
      if (!hold_cpu) low_cnt++;
      out_ready = (i % 3 == 2);
    end
    out_ready = 1'b1;
    check("t2_done", done_cnt, d0 + 1);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_words", n_xfer, 32 + CHK_EN);
    check("t2_hold_low_cycles", low_cnt, 0);
    check("t2_hold_eq_busy", hold_err, 0);

    // Test 3: abort in SEND at index 7 with ready high, then restart
    d0 = done_cnt; n_xfer = 0;
    push_range(0, 6, 1'b0);
    pulse_start();
    wait_index(5'd7, "t3_reach_idx7");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t3_valid_after_abort", out_valid, 0);
    check("t3_busy_after_abort", busy, 0);
    check("t3_hold_after_abort", hold_cpu, 0);
    repeat (5) @(posedge clk); #1;
    check("t3_no_done", done_cnt, d0);
    check("t3_words", n_xfer, 7);
    check("t3_queue_empty", exp_q.size(), 0);
    n_xfer = 0;
    push_full();
    pulse_start();
    wait_done(d0, "t3_restart_timeout");
    check("t3_restart_words", n_xfer, 32 + CHK_EN);

    // Test 4: asynchronous reset mid-dump at index 12
    n_xfer = 0;
    repeat (2) @(posedge clk); #1;
    push_range(0, 11, 1'b0);
    pulse_start();
    wait_index(5'd12, "t4_reach_idx12");
    rst_n = 1'b0;
    #2;
    check("t4_valid", out_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_hold", hold_cpu, 0);
    check("t4_done", done, 0);
    check("t4_data", out_data, 0);
    check("t4_index", out_index, 0);
    check("t4_last", out_last, 0);
    check("t4_rd_addr", rd_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("t4_idle_busy", busy, 0);
    check("t4_idle_valid", out_valid, 0);
    check("t4_words", n_xfer, 12);
    check("t4_queue_empty", exp_q.size(), 0);

    // Test 5: START_INDEX == END_INDEX == 3
    exp_b.push_back('{32'hDEADBEEF, 5'd3, CHK_EN == 0});
    if (CHK_EN != 0) exp_b.push_back('{32'hDEADBEEF, 5'h1F, 1'b1});
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 0;
    while (nb_done == 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk); #1;
    check("t5_done_pulses", nb_done, 1);
    check("t5_words", nb_xfer, 1 + CHK_EN);
    check("t5_queue_empty", exp_b.size(), 0);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    // Test 6: checksum word
    for (int k = 0; k < 32; k++) regs[k] = 32'h0;
    regs[1] = 32'hF0F0F0F0;
    regs[2] = 32'h0F0F0F0F;
    d0 = done_cnt; n_xfer = 0;
    push_range(0, 31, 1'b0);
    exp_q.push_back('{32'hFFFFFFFF, 5'h1F, 1'b1});
    pulse_start();
    wait_done(d0, "t6_done_timeout");
    check("t6_words", n_xfer, 33);
    check("t6_queue_empty", exp_q.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug/trace reader that drives the register file's read-address port and walks registers START_INDEX..END_INDEX in sequence.
- Streams each register value out over a valid/ready interface for the testbench or a debug UART bridge.
- Asserts a CPU hold while a dump is active, so register contents stay stable for its duration.
- Pure read-side initiator: it issues only read addresses and never writes the register file.

Parameters:
- DATA_WIDTH, 32, width of register data and out_data.
- ADDR_WIDTH, 5, width of the register index.
- START_INDEX, 0, first register dumped.
- END_INDEX, 31, last register dumped; must be >= START_INDEX and < 2**ADDR_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort  in  1  cancels the dump in progress.
- rd_addr  out  ADDR_WIDTH  to register file read-address port.
- rd_data  in  DATA_WIDTH  from register file read-data port; combinational, same cycle.
- out_valid  out  1  out_data/out_index are valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_WIDTH  dumped value.
- out_index  out  ADDR_WIDTH  register index of out_data.
- out_last  out  1  marks the final word of a dump.
- busy  out  1  high in any state other than IDLE.
- hold_cpu  out  1  equals busy; CPU write-enable/PC update is gated by this.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; idx=START_INDEX; rd_addr=START_INDEX; all other outputs 0.
- FSM states:
  - IDLE: on start -> READ, idx=START_INDEX.
  - READ: rd_addr=idx; on the next edge, out_data<=rd_data, out_index<=idx, out_valid<=1 -> SEND.
  - SEND: holds out_* stable until out_valid&&out_ready.
    - On transfer with idx==END_INDEX (no checksum) -> FIN.
    - Otherwise idx<=idx+1 -> READ.
  - FIN: done=1 for exactly one cycle -> IDLE.
- Latency: start at cycle N -> out_valid at N+2. Minimum 2 cycles per word with out_ready held high.
- out_valid deasserts on the edge after transfer. It is never dropped without a transfer, except on abort or reset.
- out_last=1 together with out_valid on the final word only.
- start while busy: ignored.
- abort (any non-IDLE state): -> IDLE next edge; out_valid, busy and done go 0; no done pulse. Abort wins over a simultaneous transfer.
- Index register is ADDR_WIDTH bits. No wrap-around occurs, because the increment stops at END_INDEX. END_INDEX=31 must not overflow to 0.
- START_INDEX==END_INDEX: exactly one word, with out_last=1.
- Register 0 is read like any other index and yields 0 from the register file.

Optional Feature:
- Macro: REGFILE_DUMP_CHECKSUM_EN.
- Defined:
  - A running XOR of all dumped words is kept; it is cleared on start.
  - After the END_INDEX word transfers, a CHK state emits one extra word: out_data=XOR, out_index=all ones, out_last=1. Its transfer -> FIN.
  - out_last is then 0 on the END_INDEX word.
- Undefined: no CHK state, no XOR register; out_last is on the END_INDEX word.

Decomposition:
- Package regfile_dump_pkg holds:
  - the state encoding (IDLE, READ, SEND, CHK, FIN);
  - NUM_REGS=32;
  - CHECKSUM_INDEX=5'h1F.
- No sub-module. The FSM, index counter and output register form one module; the checksum is a conditional register inside it.

Test Plan:
- Regfile preloaded with reg[k]=k*0x11111111 mod 2^32, out_ready=1, start pulse -> 32 words, indices 0..31, out_data[5]=0x55555555, out_last only on index 31, done pulse 2 cycles per word later.
- Same preload, out_ready toggled with a 1-of-3 pattern -> out_data/out_index stable while stalled, no word lost or duplicated, hold_cpu=1 throughout.
- Abort asserted in SEND at index 7 with out_ready=1 in the same cycle -> no transfer counted, IDLE next cycle, done never pulses; a later start restarts at index 0.
- rst_n pulled low mid-dump at index 12 -> all outputs 0 immediately (asynchronous); after release, stays IDLE until start.
- START_INDEX=END_INDEX=3, reg[3]=0xDEADBEEF -> single word, out_index=3, out_last=1.
- With REGFILE_DUMP_CHECKSUM_EN, reg[1]=0xF0F0F0F0, reg[2]=0x0F0F0F0F, all others 0 -> 33rd word out_data=0xFFFFFFFF, out_index=0x1F, out_last=1.
